// File: rtl/byte_tx.sv
// Asynchronous-serial byte transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Define BYTE_TX_PARITY_EN to compile in the parity bit (11-bit frames); otherwise frames are 10 bits.
module byte_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

`ifdef BYTE_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          bit_end;
`ifdef BYTE_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    assign bit_end = (cnt_q == CNT_MAX);
    assign ready   = (state_q == IDLE);
    assign tx      = tx_q;
    assign busy    = busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef BYTE_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d = START;
                    shift_d = data;
                    cnt_d   = '0;
`ifdef BYTE_TX_PARITY_EN
                    parity_d = ^data;
`endif
                end
            end
            START: if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef BYTE_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef BYTE_TX_PARITY_EN
            PARITY: if (bit_end) state_d = STOP;
`endif
            STOP: if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Line level is derived from the next state so tx changes on the same edge as the FSM.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef BYTE_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef BYTE_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef BYTE_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_byte_tx.sv
// Self-checking bench for byte_tx: every tx cycle is compared against a frame built from the byte's bits.
// Build with BYTE_TX_PARITY_EN defined to exercise parity frames.
module tb_byte_tx;

    localparam int CPB = 4;
`ifdef BYTE_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       ready, tx, busy;

    int n_pass  = 0;
    int n_total = 0;

    byte_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected line levels of one frame, one entry per bit period.
    function automatic void build_frame(input logic [7:0] d, output logic [10:0] bits);
        int ones = 0;
        bits = '1;
        bits[0] = 1'b0;
        for (int b = 0; b < 8; b++) begin
            bits[1 + b] = d[b];
            ones += int'(d[b]);
        end
`ifdef BYTE_TX_PARITY_EN
        bits[9] = logic'(ones % 2);
`endif
        bits[FRAME_BITS - 1] = 1'b1;
    endfunction

    // Starts at a negedge with the DUT idle; returns at the negedge after the frame ends.
    // noisy: toggle data/valid during the frame. chain: keep valid high with next byte nd.
    // abort_at >= 0: pull reset at that frame cycle and return after recovery.
    task automatic frame(input logic [7:0] d, input bit noisy, input bit chain,
                         input logic [7:0] nd, input int abort_at, input string tag);
        logic [10:0] bits;
        build_frame(d, bits);
        check({tag, "_ready_pre"}, {7'd0, ready}, 8'd1);
        data  = d;
        valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < FRAME_BITS * CPB; i++) begin
            check($sformatf("%s_tx_c%0d", tag, i), {7'd0, tx}, {7'd0, bits[i / CPB]});
            check($sformatf("%s_busy_c%0d", tag, i), {7'd0, busy}, 8'd1);
            check($sformatf("%s_ready_c%0d", tag, i), {7'd0, ready}, 8'd0);
            if (i == abort_at) begin
                valid = 1'b0;
                rst   = 1'b0;
                @(negedge clk);
                check({tag, "_abort_tx"}, {7'd0, tx}, 8'd1);
                check({tag, "_abort_busy"}, {7'd0, busy}, 8'd0);
                check({tag, "_abort_ready"}, {7'd0, ready}, 8'd1);
                rst = 1'b1;
                @(negedge clk);
                check({tag, "_abort_idle_tx"}, {7'd0, tx}, 8'd1);
                return;
            end
            if (chain) begin
                valid = 1'b1;
                data  = nd;
            end else if (noisy) begin
                valid = 1'($urandom_range(0, 1));
                data  = 8'hFF;
            end else begin
                valid = 1'b0;
                data  = 8'($urandom);
            end
            @(negedge clk);
        end
        if (!chain) valid = 1'b0;
        check({tag, "_end_tx"}, {7'd0, tx}, 8'd1);
        check({tag, "_end_busy"}, {7'd0, busy}, 8'd0);
        check({tag, "_end_ready"}, {7'd0, ready}, 8'd1);
        $display("frame %s byte=%02h done, checks %0d/%0d", tag, d, n_pass, n_total);
    endtask

    initial begin
        // Reset held with a pending byte: nothing may start.
        rst   = 1'b0;
        valid = 1'b1;
        data  = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_tx_%0d", i), {7'd0, tx}, 8'd1);
            check($sformatf("rst_busy_%0d", i), {7'd0, busy}, 8'd0);
        end
        rst   = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        check("rel_ready", {7'd0, ready}, 8'd1);
        check("rel_tx", {7'd0, tx}, 8'd1);
        check("rel_busy", {7'd0, busy}, 8'd0);
        $display("reset phase done, checks %0d/%0d", n_pass, n_total);

        frame(8'hA5, 1'b0, 1'b0, 8'h00, -1, "a5");
        frame(8'h07, 1'b0, 1'b0, 8'h00, -1, "p07");
        frame(8'h81, 1'b1, 1'b0, 8'h00, -1, "stab81");
        frame(8'h55, 1'b0, 1'b1, 8'hAA, -1, "b2b55");
        frame(8'hAA, 1'b0, 1'b0, 8'h00, -1, "b2bAA");
        @(negedge clk);
        frame(8'hF0, 1'b0, 1'b0, 8'h00, 4 * CPB + 1, "abortF0");
        frame(8'h12, 1'b0, 1'b0, 8'h00, -1, "post12");
        for (int k = 0; k < 6; k++) begin
            frame(8'($urandom_range(0, 255)), k[0], 1'b0, 8'h00, -1, $sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
